stage_mem: RTL

//  MEM stage of the 5-stage MIPS pipeline; consumer of the EX/MEM register produced by the EXE stage.

---
 rtl/stage_mem.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/stage_mem.sv
`default_nettype none
// ============================================================================
//  Module      : stage_mem
//  Description : MEM stage of the 5-stage MIPS pipeline. Resolves branches
//                and jumps for IF. Performs loads and stores over a req/ack
//                data-memory port with a timeout, stalls upstream while an
//                access is outstanding, and drives the registered MEM/WB
//                bundle.
//  Revision    : 1.0 - initial release
// ============================================================================
module stage_mem #(
    parameter int ADDR_W  = 10,
    parameter int TIMEOUT = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [31:0]       alu_out,
    input  logic [31:0]       data_b,
    input  logic              M,
    input  logic [1:0]        wbi,
    input  logic [4:0]        regaddr,
    input  logic              zero,
    input  logic              is_jump,
    input  logic              branch_eq,
    input  logic              branch_inc,
    input  logic [31:0]       jump_address,
    output logic              pc_src_o,
    output logic [31:0]       branch_target_o,
    output logic              stall_o,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata,
    output logic [1:0]        wb_o,
    output logic [31:0]       read_data_o,
    output logic [31:0]       alu_result_o,
    output logic [4:0]        regaddr_o,
    output logic              mem_err_o
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] c_cnt_last = CW'(TIMEOUT - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t              r_state;
    logic [CW-1:0]       r_cnt;
    logic                r_req;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [31:0]         r_wdata;
    logic [1:0]          r_wb;
    logic [31:0]         r_rdata;
    logic [31:0]         r_alu;
    logic [4:0]          r_rd;
    logic                r_err;

    logic                w_access;
    logic                w_aligned;
    logic                w_idle;
    logic                w_busy;
    logic                w_timeout;
    logic                w_taken;

    // Decode the incoming bundle and the current access status
    always_comb begin
        w_access  = in_valid & (M | wbi[0]);
        w_aligned = (alu_out[1:0] == 2'b00);
        w_idle    = (r_state == S_IDLE);
        w_busy    = (r_state == S_BUSY);
        w_timeout = w_busy & (r_cnt == c_cnt_last);
        w_taken   = is_jump | (branch_eq & zero) | (branch_inc & ~zero);
    end

    // Branch resolution and upstream hold; a timeout releases the stall
    // in the same cycle the access is abandoned
    assign pc_src_o        = in_valid & w_idle & w_taken;
    assign branch_target_o = jump_address;
    assign stall_o         = (w_idle & w_access & w_aligned) |
                             (w_busy & ~mem_ack & ~w_timeout);

    assign mem_req      = r_req;
    assign mem_we       = r_we;
    assign mem_addr     = r_addr;
    assign mem_wdata    = r_wdata;
    assign wb_o         = r_wb;
    assign read_data_o  = r_rdata;
    assign alu_result_o = r_alu;
    assign regaddr_o    = r_rd;
    assign mem_err_o    = r_err;

    // Access FSM and MEM/WB register; ack beats timeout on the same cycle
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_wb    <= 2'b00;
            r_rdata <= '0;
            r_alu   <= '0;
            r_rd    <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_access && !w_aligned) begin
                        // Misaligned: no request, flag the error, emit a bubble
                        r_err <= 1'b1;
                        r_wb  <= 2'b00;
                        r_alu <= alu_out;
                        r_rd  <= regaddr;
                    end else if (w_access) begin
                        r_addr  <= alu_out[ADDR_W+1:2];
                        r_wdata <= data_b;
                        r_we    <= M;
                        r_req   <= 1'b1;
                        r_cnt   <= '0;
                        r_wb    <= 2'b00;
                        r_state <= S_BUSY;
                    end else begin
                        r_wb  <= in_valid ? wbi : 2'b00;
                        r_alu <= alu_out;
                        r_rd  <= regaddr;
                    end
                end
                S_BUSY: begin
                    if (mem_ack) begin
                        r_req <= 1'b0;
                        r_we  <= 1'b0;
                        if (!r_we) begin
                            r_rdata <= mem_rdata;
                        end
                        r_wb    <= wbi;
                        r_alu   <= alu_out;
                        r_rd    <= regaddr;
                        r_state <= S_IDLE;
                    end else if (w_timeout) begin
                        r_req   <= 1'b0;
                        r_we    <= 1'b0;
                        r_err   <= 1'b1;
                        r_rdata <= '0;
                        r_wb    <= wbi;
                        r_alu   <= alu_out;
                        r_rd    <= regaddr;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_req   <= 1'b0;
                    r_we    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
